// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap entry / mret sequencer and trap CSR file.
// Latency: an event accepted in IDLE raises redirect_valid on the next cycle.
// Backpressure: redirect_valid/redirect_pc/stall held until redirect_ready; new events ignored meanwhile.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   exception/mcause_in/trap_pc/trap_val   synchronous exception request
//   mret                        mret executing this cycle
//   irq_ok, irq_mtip, irq_meip  interrupt boundary and pending lines
//   csr_we/csr_addr/csr_wdata   CSR write port; csr_rdata combinational read
//   stall, redirect_*           pipeline hold and PC redirect handshake
//   mie_global                  mstatus.MIE
module trap_ctrl #(
  parameter int               MXLEN       = 32,
  parameter logic [MXLEN-1:0] RESET_MTVEC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             exception,
  input  logic [MXLEN-1:0] mcause_in,
  input  logic [MXLEN-1:0] trap_pc,
  input  logic [MXLEN-1:0] trap_val,
  input  logic             mret,
  input  logic             irq_ok,
  input  logic             irq_mtip,
  input  logic             irq_meip,
  input  logic             csr_we,
  input  logic [11:0]      csr_addr,
  input  logic [MXLEN-1:0] csr_wdata,
  output logic [MXLEN-1:0] csr_rdata,
  output logic             stall,
  output logic             redirect_valid,
  input  logic             redirect_ready,
  output logic [MXLEN-1:0] redirect_pc,
  output logic             mie_global
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MIE     = 12'h304;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MTVAL   = 12'h343;
  localparam logic [11:0] ADDR_MIP     = 12'h344;

  localparam logic [MXLEN-1:0] ALIGN_MASK = {{(MXLEN-2){1'b1}}, 2'b00};
  localparam logic [MXLEN-1:0] CAUSE_MEI  = {1'b1, {(MXLEN-5){1'b0}}, 4'hB};
  localparam logic [MXLEN-1:0] CAUSE_MTI  = {1'b1, {(MXLEN-5){1'b0}}, 4'h7};

  typedef enum logic {IDLE = 1'b0, REDIRECT = 1'b1} state_t;

  state_t           state_q;
  logic             mstatus_mie_q;
  logic             mstatus_mpie_q;
  logic             mie_mtie_q;
  logic             mie_meie_q;
  logic [MXLEN-1:0] mtvec_q;
  logic [MXLEN-1:0] mepc_q;
  logic [MXLEN-1:0] mcause_q;
  logic [MXLEN-1:0] mtval_q;
  logic [MXLEN-1:0] redirect_pc_q;

  logic             mei_take;
  logic             mti_take;
  logic [MXLEN-1:0] irq_cause;
  logic [MXLEN-1:0] tvec_base;
  logic [MXLEN-1:0] irq_target;
  logic [MXLEN-1:0] trap_pc_al;

  assign mei_take   = irq_ok & mstatus_mie_q & mie_meie_q & irq_meip;
  assign mti_take   = irq_ok & mstatus_mie_q & mie_mtie_q & irq_mtip;
  assign irq_cause  = mei_take ? CAUSE_MEI : CAUSE_MTI;
  assign tvec_base  = mtvec_q & ALIGN_MASK;
  // 4*cause[MXLEN-2:0] modulo 2^MXLEN only keeps cause[MXLEN-3:0]; the sum wraps.
  assign irq_target = mtvec_q[0] ? tvec_base + {irq_cause[MXLEN-3:0], 2'b00} : tvec_base;
  assign trap_pc_al = trap_pc & ALIGN_MASK;

  assign stall          = (state_q == REDIRECT);
  assign redirect_valid = (state_q == REDIRECT);
  assign redirect_pc    = redirect_pc_q;
  assign mie_global     = mstatus_mie_q;

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      ADDR_MSTATUS: begin
        csr_rdata[12:11] = 2'b11;
        csr_rdata[7]     = mstatus_mpie_q;
        csr_rdata[3]     = mstatus_mie_q;
      end
      ADDR_MIE: begin
        csr_rdata[11] = mie_meie_q;
        csr_rdata[7]  = mie_mtie_q;
      end
      ADDR_MTVEC:  csr_rdata = mtvec_q;
      ADDR_MEPC:   csr_rdata = mepc_q;
      ADDR_MCAUSE: csr_rdata = mcause_q;
      ADDR_MTVAL:  csr_rdata = mtval_q;
      ADDR_MIP: begin
        csr_rdata[11] = irq_meip;
        csr_rdata[7]  = irq_mtip;
      end
      default:     csr_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_mtie_q     <= 1'b0;
      mie_meie_q     <= 1'b0;
      mtvec_q        <= RESET_MTVEC;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
      redirect_pc_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // Accepted events take the cycle; any CSR write alongside is dropped.
          if (exception) begin
            mepc_q         <= trap_pc_al;
            mcause_q       <= mcause_in;
            mtval_q        <= trap_val;
            mstatus_mpie_q <= mstatus_mie_q;
            mstatus_mie_q  <= 1'b0;
            redirect_pc_q  <= tvec_base;
            state_q        <= REDIRECT;
          end else if (mret) begin
            mstatus_mie_q  <= mstatus_mpie_q;
            mstatus_mpie_q <= 1'b1;
            redirect_pc_q  <= mepc_q;
            state_q        <= REDIRECT;
          end else if (mei_take || mti_take) begin
            mepc_q         <= trap_pc_al;
            mcause_q       <= irq_cause;
            mtval_q        <= '0;
            mstatus_mpie_q <= mstatus_mie_q;
            mstatus_mie_q  <= 1'b0;
            redirect_pc_q  <= irq_target;
            state_q        <= REDIRECT;
          end else if (csr_we) begin
            case (csr_addr)
              ADDR_MSTATUS: begin
                mstatus_mie_q  <= csr_wdata[3];
                mstatus_mpie_q <= csr_wdata[7];
              end
              ADDR_MIE: begin
                mie_mtie_q <= csr_wdata[7];
                mie_meie_q <= csr_wdata[11];
              end
              // Reserved modes 2/3 collapse to direct.
              ADDR_MTVEC:  mtvec_q  <= {csr_wdata[MXLEN-1:2], 1'b0, (csr_wdata[1:0] == 2'b01)};
              ADDR_MEPC:   mepc_q   <= csr_wdata & ALIGN_MASK;
              ADDR_MCAUSE: mcause_q <= csr_wdata;
              ADDR_MTVAL:  mtval_q  <= csr_wdata;
              default: ;
            endcase
          end
        end
        REDIRECT: begin
          if (redirect_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
module tb_trap_ctrl;
  localparam logic [31:0] RST_TVEC = 32'h0000_0040;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        exception = 1'b0;
  logic [31:0] mcause_in = '0;
  logic [31:0] trap_pc = '0;
  logic [31:0] trap_val = '0;
  logic        mret = 1'b0;
  logic        irq_ok = 1'b0;
  logic        irq_mtip = 1'b0;
  logic        irq_meip = 1'b0;
  logic        csr_we = 1'b0;
  logic [11:0] csr_addr = '0;
  logic [31:0] csr_wdata = '0;
  logic [31:0] csr_rdata;
  logic        stall;
  logic        redirect_valid;
  logic        redirect_ready = 1'b0;
  logic [31:0] redirect_pc;
  logic        mie_global;

  int checks = 0;
  int failures = 0;

  trap_ctrl #(.MXLEN(32), .RESET_MTVEC(RST_TVEC)) dut (
    .clk(clk), .rst_n(rst_n), .exception(exception), .mcause_in(mcause_in),
    .trap_pc(trap_pc), .trap_val(trap_val), .mret(mret), .irq_ok(irq_ok),
    .irq_mtip(irq_mtip), .irq_meip(irq_meip), .csr_we(csr_we), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
    .redirect_pc(redirect_pc), .mie_global(mie_global)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    csr_addr = a; csr_wdata = d; csr_we = 1'b1;
    step();
    csr_we = 1'b0;
  endtask

  task automatic accept();
    redirect_ready = 1'b1;
    step();
    redirect_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rst_stall got %b exp 0", stall); end
    checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got %b exp 0", redirect_valid); end
    checks++; if (redirect_pc !== 32'h0) begin failures++; $display("FAIL rst_pc got %h exp 0", redirect_pc); end
    csr_addr = 12'h305; #1;
    checks++; if (csr_rdata !== RST_TVEC) begin failures++; $display("FAIL rst_mtvec got %h exp %h", csr_rdata, RST_TVEC); end
    csr_addr = 12'h300; #1;
    checks++; if (csr_rdata !== 32'h0000_1800) begin failures++; $display("FAIL rst_mstatus got %h exp 00001800", csr_rdata); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_direct_exception();
    csr_write(12'h305, 32'h100);
    csr_write(12'h300, 32'h8);
    checks++; if (mie_global !== 1'b1) begin failures++; $display("FAIL mie_global_set got %b exp 1", mie_global); end
    exception = 1'b1; mcause_in = 32'h2; trap_pc = 32'h2006; trap_val = 32'hDEAD;
    step();
    exception = 1'b0;
    checks++; if (redirect_valid !== 1'b1) begin failures++; $display("FAIL exc_valid got %b exp 1", redirect_valid); end
    checks++; if (redirect_pc !== 32'h100) begin failures++; $display("FAIL exc_pc got %h exp 00000100", redirect_pc); end
    csr_addr = 12'h341; #1;
    checks++; if (csr_rdata !== 32'h2004) begin failures++; $display("FAIL exc_mepc got %h exp 00002004", csr_rdata); end
    csr_addr = 12'h342; #1;
    checks++; if (csr_rdata !== 32'h2) begin failures++; $display("FAIL exc_mcause got %h exp 00000002", csr_rdata); end
    csr_addr = 12'h343; #1;
    checks++; if (csr_rdata !== 32'hDEAD) begin failures++; $display("FAIL exc_mtval got %h exp 0000dead", csr_rdata); end
    csr_addr = 12'h300; #1;
    checks++; if (csr_rdata !== 32'h1880) begin failures++; $display("FAIL exc_mstatus got %h exp 00001880", csr_rdata); end
  endtask

  task automatic test_handshake_hold();
    // Events and CSR writes presented while redirecting must be ignored.
    exception = 1'b1; mcause_in = 32'h9; trap_pc = 32'h7000;
    csr_we = 1'b1; csr_addr = 12'h305; csr_wdata = 32'h999;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (redirect_valid !== 1'b1 || stall !== 1'b1) begin failures++; $display("FAIL hold_valid cyc%0d got v=%b s=%b exp 1/1", i, redirect_valid, stall); end
      checks++; if (redirect_pc !== 32'h100) begin failures++; $display("FAIL hold_pc cyc%0d got %h exp 00000100", i, redirect_pc); end
    end
    exception = 1'b0; csr_we = 1'b0;
    accept();
    checks++; if (redirect_valid !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL hold_release got v=%b s=%b exp 0/0", redirect_valid, stall); end
    csr_addr = 12'h305; #1;
    checks++; if (csr_rdata !== 32'h100) begin failures++; $display("FAIL hold_mtvec got %h exp 00000100", csr_rdata); end
    csr_addr = 12'h342; #1;
    checks++; if (csr_rdata !== 32'h2) begin failures++; $display("FAIL hold_mcause got %h exp 00000002", csr_rdata); end
  endtask

  task automatic test_vectored_irq();
    csr_write(12'h305, 32'h201);
    csr_write(12'h304, 32'h880);
    csr_write(12'h300, 32'h8);
    csr_addr = 12'h304; #1;
    checks++; if (csr_rdata !== 32'h880) begin failures++; $display("FAIL vec_mie got %h exp 00000880", csr_rdata); end
    irq_mtip = 1'b1; irq_meip = 1'b1; irq_ok = 1'b0; trap_pc = 32'h3000;
    step();
    checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL vec_irq_ok0 got %b exp 0", redirect_valid); end
    csr_addr = 12'h344; #1;
    checks++; if (csr_rdata !== 32'h880) begin failures++; $display("FAIL vec_mip got %h exp 00000880", csr_rdata); end
    irq_ok = 1'b1;
    step();
    irq_ok = 1'b0;
    checks++; if (redirect_valid !== 1'b1) begin failures++; $display("FAIL vec_valid got %b exp 1", redirect_valid); end
    checks++; if (redirect_pc !== 32'h22C) begin failures++; $display("FAIL vec_pc got %h exp 0000022c", redirect_pc); end
    csr_addr = 12'h342; #1;
    checks++; if (csr_rdata !== 32'h8000_000B) begin failures++; $display("FAIL vec_mcause got %h exp 8000000b", csr_rdata); end
    csr_addr = 12'h341; #1;
    checks++; if (csr_rdata !== 32'h3000) begin failures++; $display("FAIL vec_mepc got %h exp 00003000", csr_rdata); end
    csr_addr = 12'h343; #1;
    checks++; if (csr_rdata !== 32'h0) begin failures++; $display("FAIL vec_mtval got %h exp 0", csr_rdata); end
    accept();
    // MIE is now clear, so a pending timer interrupt must wait.
    irq_meip = 1'b0; irq_ok = 1'b1;
    step();
    checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL mti_masked got %b exp 0", redirect_valid); end
    csr_write(12'h300, 32'h8);
    step();
    irq_ok = 1'b0; irq_mtip = 1'b0;
    checks++; if (redirect_pc !== 32'h21C || redirect_valid !== 1'b1) begin failures++; $display("FAIL mti_pc got %h v=%b exp 0000021c v=1", redirect_pc, redirect_valid); end
    csr_addr = 12'h342; #1;
    checks++; if (csr_rdata !== 32'h8000_0007) begin failures++; $display("FAIL mti_mcause got %h exp 80000007", csr_rdata); end
    accept();
  endtask

  task automatic test_priority_mret();
    csr_write(12'h300, 32'h8);
    exception = 1'b1; mcause_in = 32'h5; trap_pc = 32'h2006; trap_val = 32'h44;
    mret = 1'b1; irq_meip = 1'b1; irq_ok = 1'b1;
    step();
    exception = 1'b0; mret = 1'b0; irq_meip = 1'b0; irq_ok = 1'b0;
    checks++; if (redirect_pc !== 32'h200) begin failures++; $display("FAIL prio_pc got %h exp 00000200", redirect_pc); end
    csr_addr = 12'h342; #1;
    checks++; if (csr_rdata !== 32'h5) begin failures++; $display("FAIL prio_mcause got %h exp 00000005", csr_rdata); end
    csr_addr = 12'h341; #1;
    checks++; if (csr_rdata !== 32'h2004) begin failures++; $display("FAIL prio_mepc got %h exp 00002004", csr_rdata); end
    csr_addr = 12'h300; #1;
    checks++; if (csr_rdata !== 32'h1880) begin failures++; $display("FAIL prio_mstatus got %h exp 00001880", csr_rdata); end
    accept();
    mret = 1'b1;
    step();
    mret = 1'b0;
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h2004) begin failures++; $display("FAIL mret_pc got %h v=%b exp 00002004 v=1", redirect_pc, redirect_valid); end
    csr_addr = 12'h300; #1;
    checks++; if (csr_rdata !== 32'h1888) begin failures++; $display("FAIL mret_mstatus got %h exp 00001888", csr_rdata); end
    accept();
  endtask

  task automatic test_edge_cases();
    csr_write(12'h341, 32'h1233);
    csr_addr = 12'h341; #1;
    checks++; if (csr_rdata !== 32'h1230) begin failures++; $display("FAIL mepc_align got %h exp 00001230", csr_rdata); end
    csr_write(12'h305, 32'h303);
    csr_addr = 12'h305; #1;
    checks++; if (csr_rdata !== 32'h300) begin failures++; $display("FAIL mtvec_mode3 got %h exp 00000300", csr_rdata); end
    csr_addr = 12'h340; #1;
    checks++; if (csr_rdata !== 32'h0) begin failures++; $display("FAIL unmapped got %h exp 0", csr_rdata); end
    redirect_ready = 1'b1;
    step();
    redirect_ready = 1'b0;
    checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL ready_idle got %b exp 0", redirect_valid); end
    exception = 1'b1; mcause_in = 32'h1; trap_pc = 32'h40; trap_val = 32'h77;
    csr_we = 1'b1; csr_addr = 12'h304; csr_wdata = 32'h0;
    step();
    exception = 1'b0; csr_we = 1'b0;
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h300) begin failures++; $display("FAIL drop_pc got %h v=%b exp 00000300 v=1", redirect_pc, redirect_valid); end
    csr_addr = 12'h304; #1;
    checks++; if (csr_rdata !== 32'h880) begin failures++; $display("FAIL drop_mie got %h exp 00000880", csr_rdata); end
    csr_addr = 12'h343; #1;
    checks++; if (csr_rdata !== 32'h77) begin failures++; $display("FAIL drop_mtval got %h exp 00000077", csr_rdata); end
    // Reset while redirecting: outputs drop without waiting for a clock.
    rst_n = 1'b0; #1;
    checks++; if (redirect_valid !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL rst_redir got v=%b s=%b exp 0/0", redirect_valid, stall); end
    checks++; if (redirect_pc !== 32'h0) begin failures++; $display("FAIL rst_redir_pc got %h exp 0", redirect_pc); end
    csr_addr = 12'h305; #1;
    checks++; if (csr_rdata !== RST_TVEC) begin failures++; $display("FAIL rst_redir_mtvec got %h exp %h", csr_rdata, RST_TVEC); end
    #2 rst_n = 1'b1;
    step();
    step();
    checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL post_rst_valid got %b exp 0", redirect_valid); end
  endtask

  initial begin
    test_reset();
    test_direct_exception();
    test_handshake_hold();
    test_vectored_irq();
    test_priority_mret();
    test_edge_cases();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Sequences machine-mode trap entry and `mret` for the RV32 core.
- Consumes the one-hot-collapsed `exception`/`mcause` pair from the exception-priority logic, plus the timer and external interrupt lines.
- Owns mstatus.MIE/MPIE, mie, mtvec, mepc, mcause and mtval.
- Stalls the pipeline and issues a PC redirect through a valid/ready handshake.

Parameters:
- MXLEN, 32, register/data width.
- RESET_MTVEC, 32'h0000_0000, mtvec reset value (mode bits [1:0] must be 0).

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- exception  in  1  synchronous exception on the current instruction.
- mcause_in  in  MXLEN  cause code, valid when exception=1.
- trap_pc  in  MXLEN  PC of the faulting instruction, or of the next instruction at an interrupt boundary.
- trap_val  in  MXLEN  faulting address/instruction written to mtval.
- mret  in  1  mret executing this cycle.
- irq_ok  in  1  pipeline is at an instruction boundary; interrupts may be taken.
- irq_mtip  in  1  machine timer interrupt pending (level).
- irq_meip  in  1  machine external interrupt pending (level).
- csr_we  in  1  CSR write strobe.
- csr_addr  in  12  CSR address.
- csr_wdata  in  MXLEN  CSR write data.
- csr_rdata  out  MXLEN  combinational read of csr_addr; 0 for unmapped addresses.
- stall  out  1  pipeline hold.
- redirect_valid  out  1  redirect request.
- redirect_ready  in  1  fetch accepts the redirect.
- redirect_pc  out  MXLEN  target PC.
- mie_global  out  1  mstatus.MIE.

Behaviour:
- CSR map:
  - mstatus 0x300: MIE bit 3, MPIE bit 7, MPP[12:11] reads 2'b11, all other bits read 0.
  - mie 0x304: MTIE bit 7, MEIE bit 11, writable.
  - mtvec 0x305: BASE[MXLEN-1:2], MODE[1:0]. MODE 0 = direct, 1 = vectored. Writes with MODE 2 or 3 store MODE=0.
  - mepc 0x341: bits [1:0] forced to 0 on every write.
  - mcause 0x342, mtval 0x343: fully writable.
  - mip 0x344: read-only, MTIP bit 7 = irq_mtip, MEIP bit 11 = irq_meip.
- Reset (rst_n=0, async):
  - state=IDLE; stall=0, redirect_valid=0, redirect_pc=0.
  - mstatus MIE=MPIE=0; mie=0; mepc=mcause=mtval=0; mtvec=RESET_MTVEC.
- FSM, states IDLE and REDIRECT. stall = (state==REDIRECT). redirect_valid = (state==REDIRECT).
- IDLE evaluates events each cycle, priority exception > mret > MEI > MTI:
  - Exception:
    - mepc ← {trap_pc[MXLEN-1:2], 2'b00}, mcause ← mcause_in, mtval ← trap_val.
    - MPIE ← MIE, MIE ← 0.
    - redirect_pc ← BASE<<2.
    - Go to REDIRECT.
  - mret:
    - MIE ← MPIE, MPIE ← 1.
    - redirect_pc ← mepc.
    - Go to REDIRECT.
  - Interrupt:
    - MEI condition: irq_ok & MIE & MEIE & irq_meip, giving cause 0x8000_000B. MTI condition: irq_ok & MIE & MTIE & irq_mtip, giving cause 0x8000_0007.
    - mepc ← trap_pc (aligned as above), mcause ← cause, mtval ← 0.
    - MPIE ← MIE, MIE ← 0.
    - redirect_pc ← BASE<<2 in direct mode, or (BASE<<2) + 4×cause[MXLEN-2:0] in vectored mode.
    - Go to REDIRECT.
  - All updates are registered at the edge that leaves IDLE. Latency from event cycle to redirect_valid=1 is one cycle.
- REDIRECT:
  - redirect_valid and redirect_pc are held stable until redirect_ready=1.
  - On that edge, return to IDLE; redirect_valid falls the next cycle.
  - exception, mret, irq_* and csr_we are ignored while in REDIRECT.
- Simultaneous events:
  - A CSR write in the same IDLE cycle as an accepted event is dropped. Trap updates win, including writes to non-trap CSRs.
  - redirect_ready sampled in IDLE has no effect.
- Arithmetic: the vectored target wraps modulo 2^MXLEN; no overflow flag.
- Reset asserted in REDIRECT: outputs drop immediately (async) and no redirect is issued.

Test Plan:
- Reset then reads: csr_rdata(0x305)=RESET_MTVEC, csr_rdata(0x300)=0x0000_1800, stall=0.
- Direct-mode exception:
  - Stimulus: mtvec=0x100, MIE=1, exception with mcause_in=2, trap_pc=0x2006, trap_val=0xDEAD.
  - Next cycle: redirect_valid=1, redirect_pc=0x100.
  - CSRs: mepc=0x2004, mcause=2, mtval=0xDEAD, mstatus=0x1880.
- Handshake hold: redirect_ready low for 3 cycles → redirect_valid and stall stay 1 with stable redirect_pc; ready high → IDLE on the next edge.
- Vectored interrupt:
  - Stimulus: mtvec=0x201, mie=0x880, MIE=1, irq_mtip=irq_meip=1, irq_ok=1, trap_pc=0x3000.
  - Response: mcause=0x8000_000B, redirect_pc=0x22C, mepc=0x3000, mtval=0.
  - Repeat with irq_ok=0 → no trap.
- Priority and mret:
  - exception, mret and irq_meip in the same cycle → exception taken.
  - A later mret with mepc=0x2004 → redirect_pc=0x2004, mstatus=0x1888.
- Edge cases:
  - csr_we to mepc with 0x1233 → reads 0x1230.
  - csr_we in the same cycle as an exception → write dropped.
  - rst_n low during REDIRECT → redirect_valid=0 immediately.
